// File: rtl/exponentiation_mod.sv
// Modular exponentiation using the right-to-left binary method, with interleaved shift-add modular products.
// Optional MODEXP_EARLY_EXIT_EN stops once the remaining exponent is zero; without it, latency does not depend on the exponent value.
module exponentiation_mod #(
  parameter int WIDTH     = 64,
  parameter int EXP_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic [WIDTH-1:0]     result,
  output logic                 done,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic [1:0] {IDLE, CHECK, STEP, UPDATE} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t               state_reg;
  logic [WIDTH-1:0]     base_reg;
  logic [EXP_WIDTH-1:0] exp_reg;
  logic [WIDTH-1:0]     mod_reg;
  logic [WIDTH-1:0]     acc_reg;
  logic [WIDTH-1:0]     sq_reg;
  logic [CW-1:0]        cnt_reg;
  logic [WIDTH-1:0]     prod_reg  [2];
  logic [WIDTH-1:0]     prod_next [2];
  logic [WIDTH-1:0]     addend    [2];
  logic [WIDTH:0]       mod_ext;
  logic                 mul_bit;
  logic                 last_iter;
  logic [EXP_WIDTH-1:0] exp_shifted;
  logic [WIDTH-1:0]     acc_new;

`ifndef MODEXP_EARLY_EXIT_EN
  localparam int IW = $clog2(EXP_WIDTH + 1);
  logic [IW-1:0] iter_reg;
`endif

  // Lane 0 forms acc*sq, lane 1 forms sq*sq; both share sq as the multiplier.
  assign addend[0] = acc_reg;
  assign addend[1] = sq_reg;
  assign mod_ext   = {1'b0, mod_reg};
  assign mul_bit   = sq_reg[cnt_reg];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      logic [WIDTH:0]   dbl;
      logic [WIDTH-1:0] dbl_red;
      logic [WIDTH:0]   sum;
      logic [WIDTH-1:0] sum_red;

      // Operands are below m, so one conditional subtract suffices and the
      // reduced value always fits back in WIDTH bits.
      assign dbl     = {prod_reg[gi], 1'b0};
      assign dbl_red = (dbl >= mod_ext) ? (dbl[WIDTH-1:0] - mod_reg) : dbl[WIDTH-1:0];
      assign sum     = {1'b0, dbl_red} + {1'b0, addend[gi]};
      assign sum_red = (sum >= mod_ext) ? (sum[WIDTH-1:0] - mod_reg) : sum[WIDTH-1:0];
      assign prod_next[gi] = mul_bit ? sum_red : dbl_red;
    end
  endgenerate

  assign exp_shifted = exp_reg >> 1;
  assign acc_new     = exp_reg[0] ? prod_reg[0] : acc_reg;

`ifdef MODEXP_EARLY_EXIT_EN
  assign last_iter = (exp_shifted == '0);
`else
  assign last_iter = (iter_reg == IW'(EXP_WIDTH - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      base_reg  <= '0;
      exp_reg   <= '0;
      mod_reg   <= '0;
      acc_reg   <= '0;
      sq_reg    <= '0;
      cnt_reg   <= '0;
      for (int i = 0; i < 2; i++) prod_reg[i] <= '0;
`ifndef MODEXP_EARLY_EXIT_EN
      iter_reg  <= '0;
`endif
      result    <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            base_reg  <= base;
            exp_reg   <= exponent;
            mod_reg   <= modulus;
            err       <= 1'b0;
            busy      <= 1'b1;
            state_reg <= CHECK;
          end else begin
            busy <= 1'b0;
          end
        end

        CHECK: begin
          if ((mod_reg < WIDTH'(2)) || (base_reg >= mod_reg)) begin
            result    <= '0;
            err       <= 1'b1;
            done      <= 1'b1;
            state_reg <= IDLE;
          end
`ifdef MODEXP_EARLY_EXIT_EN
          else if (exp_reg == '0) begin
            result    <= WIDTH'(1);
            done      <= 1'b1;
            state_reg <= IDLE;
          end
`endif
          else begin
            acc_reg   <= WIDTH'(1);
            sq_reg    <= base_reg;
            cnt_reg   <= CW'(WIDTH - 1);
            for (int i = 0; i < 2; i++) prod_reg[i] <= '0;
`ifndef MODEXP_EARLY_EXIT_EN
            iter_reg  <= '0;
`endif
            state_reg <= STEP;
          end
        end

        STEP: begin
          for (int i = 0; i < 2; i++) prod_reg[i] <= prod_next[i];
          if (cnt_reg == '0) begin
            state_reg <= UPDATE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end

        UPDATE: begin
          sq_reg  <= prod_reg[1];
          acc_reg <= acc_new;
          exp_reg <= exp_shifted;
          cnt_reg <= CW'(WIDTH - 1);
          for (int i = 0; i < 2; i++) prod_reg[i] <= '0;
`ifndef MODEXP_EARLY_EXIT_EN
          iter_reg <= iter_reg + 1'b1;
`endif
          if (last_iter) begin
            result    <= acc_new;
            done      <= 1'b1;
            state_reg <= IDLE;
          end else begin
            state_reg <= STEP;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
